// File: rtl/nps_acc_pkg.sv
// rtl/nps_acc_pkg.sv - shared state encoding and width constants for nps_acc
package nps_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_CNT_WIDTH  = 9;
    localparam int SUM_WIDTH      = DEF_DATA_WIDTH + DEF_CNT_WIDTH;
    localparam int MAX_CNT        = 1 << DEF_CNT_WIDTH;

endpackage

// File: rtl/nps_acc_if.sv
// rtl/nps_acc_if.sv - control, sample stream and result bundle of nps_acc
interface nps_acc_if
    import nps_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
    logic                            start;
    logic                            set;
    logic                            vi;
    logic                            fi;
    logic [DATA_WIDTH-1:0]           datai;
    logic                            vo;
    logic                            fo;
    logic [DATA_WIDTH+CNT_WIDTH-1:0] sumo;
    logic [DATA_WIDTH-1:0]           maxo;
    logic [CNT_WIDTH:0]              cnto;
    logic                            ovf;

    modport master (
        output start, set, vi, fi, datai,
        input  vo, fo, sumo, maxo, cnto, ovf
    );

    modport slave (
        input  start, set, vi, fi, datai,
        output vo, fo, sumo, maxo, cnto, ovf
    );
endinterface

// File: rtl/nps_acc.sv
// rtl/nps_acc.sv - per-frame sum, max and word count over the NPS_rom sample stream
module nps_acc
    import nps_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic   clk,
    input  logic   reset_x,
    nps_acc_if.slave bus
);
    localparam int SW = DATA_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH:0] CNT_FULL = {1'b1, {CNT_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_nxt;
    logic                  clear;
    logic                  acc_en;
    logic [SW-1:0]         sum_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic [CNT_WIDTH:0]    cnt_q;
    logic                  ovf_q;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.set) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) state_nxt = ST_ACC;
                ST_ACC: begin
                    if (bus.start)   state_nxt = ST_ACC;
                    else if (bus.fi) state_nxt = ST_OUT;
                end
                ST_OUT:  state_nxt = ST_DONE;
                ST_DONE: if (bus.start) state_nxt = ST_ACC;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // OUT ignores start, so a frame result can never be cleared during its vo pulse
    always_comb begin
        bus.vo = (state == ST_OUT);
        bus.fo = (state == ST_DONE);
        clear  = bus.set | (bus.start & (state != ST_OUT));
        acc_en = (state == ST_ACC) & bus.vi & ~clear;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (acc_en) begin
            if (cnt_q < CNT_FULL) begin
                sum_q <= sum_q + SW'(bus.datai);
                if (bus.datai > max_q) max_q <= bus.datai;
                cnt_q <= cnt_q + 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.sumo = sum_q;
    assign bus.maxo = max_q;
    assign bus.cnto = cnt_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nps_acc.sv
// tb/tb_nps_acc.sv - scoreboard bench for nps_acc frame statistics
module tb_nps_acc;
    import nps_acc_pkg::*;

    typedef struct {
        logic [SUM_WIDTH-1:0]      sum;
        logic [DEF_DATA_WIDTH-1:0] max;
        logic [DEF_CNT_WIDTH:0]    cnt;
        logic                      ovf;
    } res_t;

    logic clk;
    logic reset_x;
    int   n_checks;
    int   n_pass;
    int   vo_count;
    int   exp_vo;
    logic prev_vo;
    res_t exp_q[$];

    nps_acc_if #(.DATA_WIDTH(DEF_DATA_WIDTH), .CNT_WIDTH(DEF_CNT_WIDTH)) bus ();

    nps_acc #(.DATA_WIDTH(DEF_DATA_WIDTH), .CNT_WIDTH(DEF_CNT_WIDTH)) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // scoreboard: every vo pulse pops one expected frame result
    always @(negedge clk) begin
        if (reset_x && bus.vo) begin
            vo_count++;
            check("vo_width", 64'(prev_vo), 64'd0);
            if (exp_q.size() == 0) begin
                check("vo_unexpected", 64'd1, 64'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sumo", 64'(bus.sumo), 64'(e.sum));
                check("maxo", 64'(bus.maxo), 64'(e.max));
                check("cnto", 64'(bus.cnto), 64'(e.cnt));
                check("ovf",  64'(bus.ovf),  64'(e.ovf));
            end
        end
        prev_vo = bus.vo;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        bus.vi    = 1'b0;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [DEF_DATA_WIDTH-1:0] d);
        bus.vi    = 1'b1;
        bus.datai = d;
        cycle();
        bus.vi    = 1'b0;
    endtask

    task automatic finish_frame(input bit with_word, input logic [DEF_DATA_WIDTH-1:0] d,
                                input logic [SUM_WIDTH-1:0] esum, input logic [DEF_DATA_WIDTH-1:0] emax,
                                input logic [DEF_CNT_WIDTH:0] ecnt, input logic eovf);
        res_t e;
        e.sum = esum; e.max = emax; e.cnt = ecnt; e.ovf = eovf;
        exp_q.push_back(e);
        exp_vo++;
        bus.fi    = 1'b1;
        bus.vi    = with_word;
        bus.datai = d;
        cycle();
        bus.fi = 1'b0;
        bus.vi = 1'b0;
        @(negedge clk);
        check("vo_after_fi", 64'(bus.vo), 64'd1);
        check("fo_during_vo", 64'(bus.fo), 64'd0);
        @(negedge clk);
        check("vo_drop", 64'(bus.vo), 64'd0);
        check("fo_rise", 64'(bus.fo), 64'd1);
        @(negedge clk);
        check("fo_hold", 64'(bus.fo), 64'd1);
        cycle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_sumo"}, 64'(bus.sumo), 64'd0);
        check({tag, "_maxo"}, 64'(bus.maxo), 64'd0);
        check({tag, "_cnto"}, 64'(bus.cnto), 64'd0);
        check({tag, "_ovf"},  64'(bus.ovf),  64'd0);
        check({tag, "_fo"},   64'(bus.fo),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_pass = 0; vo_count = 0; exp_vo = 0; prev_vo = 1'b0;
        reset_x = 1'b0;
        bus.start = 1'b0; bus.set = 1'b0; bus.vi = 1'b0; bus.fi = 1'b0; bus.datai = '0;
        @(negedge clk);
        check_cleared("reset");
        check("reset_vo", 64'(bus.vo), 64'd0);
        cycle();
        cycle();
        reset_x = 1'b1;
        cycle();

        // ramp frame
        start_frame();
        for (int i = 0; i < 512; i++) send(24'(i));
        finish_frame(1'b0, '0, 33'h1FF00, 24'h1FF, 10'd512, 1'b0);

        // restart from DONE
        start_frame();
        @(negedge clk);
        check_cleared("restart");
        cycle();
        for (int i = 0; i < 4; i++) send(24'd2);
        finish_frame(1'b0, '0, 33'd8, 24'd2, 10'd4, 1'b0);

        // full-scale frame
        start_frame();
        for (int i = 0; i < 512; i++) send(24'hFFFFFF);
        finish_frame(1'b0, '0, 33'h1_FFFF_FE00, 24'hFFFFFF, 10'd512, 1'b0);

        // 513 words: the last one is dropped
        start_frame();
        for (int i = 0; i < 513; i++) send(24'd1);
        finish_frame(1'b0, '0, 33'd512, 24'd1, 10'd512, 1'b1);

        // final word coincides with fi
        start_frame();
        send(24'd5);
        send(24'd9);
        finish_frame(1'b1, 24'd3, 33'd17, 24'd9, 10'd3, 1'b0);

        // asynchronous reset mid-frame
        start_frame();
        for (int i = 0; i < 100; i++) send(24'd4);
        check("pre_reset_cnto", 64'(bus.cnto), 64'd100);
        reset_x = 1'b0;
        #1;
        check_cleared("async_reset");
        check("async_reset_vo", 64'(bus.vo), 64'd0);
        cycle();
        reset_x = 1'b1;
        repeat (4) cycle();
        check("reset_no_vo", 64'(vo_count), 64'(exp_vo));

        // set mid-frame, then a fresh frame
        start_frame();
        for (int i = 0; i < 100; i++) send(24'd6);
        bus.set = 1'b1;
        cycle();
        bus.set = 1'b0;
        @(negedge clk);
        check_cleared("set_abort");
        cycle();
        send(24'd9);
        repeat (3) cycle();
        check("set_no_vo", 64'(vo_count), 64'(exp_vo));
        check("idle_ignores_vi", 64'(bus.cnto), 64'd0);
        start_frame();
        send(24'd7);
        send(24'd7);
        finish_frame(1'b0, '0, 33'd14, 24'd7, 10'd2, 1'b0);

        // set and start together: set wins, vi stays ignored
        bus.set = 1'b1;
        bus.start = 1'b1;
        cycle();
        bus.set = 1'b0;
        bus.start = 1'b0;
        send(24'd5);
        @(negedge clk);
        check("set_wins_cnto", 64'(bus.cnto), 64'd0);
        check("set_wins_fo", 64'(bus.fo), 64'd0);
        cycle();

        // empty frame with fi already high at start
        bus.fi = 1'b1;
        start_frame();
        finish_frame(1'b0, '0, 33'd0, 24'd0, 10'd0, 1'b0);

        repeat (3) cycle();
        check("vo_total", 64'(vo_count), 64'(exp_vo));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nps_acc.md
# nps_acc

Frame statistics stage placed directly downstream of `NPS_rom`. It consumes the ROM's 24-bit valid-qualified data stream (`vi`/`fi`), accumulates the sum, maximum and word count over one frame, and presents the three results with a one-cycle `vo` pulse followed by a held `fo` completion flag. It closes the ROM readback path so the bench and host see one result word per frame instead of 512 samples.

## Interface
Parameters:
- `DATA_WIDTH`, 24: input data width, matching `NPS_rom` output.
- `CNT_WIDTH`, 9: log2 of the maximum frame length; at most 2^CNT_WIDTH words are accumulated.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_x`  in  1  asynchronous, active-low reset.
- `start`  in  1  arms a new frame and clears the accumulators.
- `set`  in  1  synchronous clear to IDLE; priority over `start`.
- `vi`  in  1  `datai` valid.
- `fi`  in  1  frame end; level, may stay high after the last word.
- `datai`  in  DATA_WIDTH  unsigned sample (ROM `datao`).
- `vo`  out  1  result-valid pulse, one cycle.
- `fo`  out  1  frame-done flag, held.
- `sumo`  out  DATA_WIDTH+CNT_WIDTH  unsigned sum.
- `maxo`  out  DATA_WIDTH  maximum sample.
- `cnto`  out  CNT_WIDTH+1  accepted word count, 0..2^CNT_WIDTH.
- `ovf`  out  1  at least one word was dropped because the count was full.

## Operation
- States: IDLE, ACC, OUT, DONE.
- IDLE: `vi`, `fi` ignored. On `start`, clear sum, max, count and `ovf`, then go to ACC.
- ACC: on `vi`, if count < 2^CNT_WIDTH, then sum += `datai`, max = max(max, `datai`), count += 1. Otherwise drop the word and set `ovf`. On `fi`, go to OUT. A `vi` in the same cycle as `fi` is accumulated first. `start` in ACC restarts: clear and stay in ACC, and any `vi` in that cycle is discarded.
- OUT: `vo`=1 for exactly this cycle, then go to DONE. `start`, `vi` and `fi` are ignored.
- DONE: `fo`=1. `fi` and `vi` are ignored. `start` clears and goes to ACC, with `fo` dropping the next cycle.
- `set`, in any state: clear all accumulators and `ovf`, then go to IDLE.
- Arithmetic: unsigned, no wrap. The sum width guarantees that 2^CNT_WIDTH × (2^DATA_WIDTH−1) fits exactly.
- `sumo`, `maxo`, `cnto` and `ovf` are registered and show the live accumulators. They are stable from OUT until the next `start` or `set`.

## Timing
- Reset (`reset_x`=0, asynchronous): state IDLE. `vo`, `fo`, `sumo`, `maxo`, `cnto` and `ovf` are all 0.
- `fi` sampled high at edge N, so `vo`=1 in cycle N+1 and `fo`=1 from cycle N+2 onward.
- A `vi` word sampled at edge N is reflected in the outputs after edge N.
- `reset_x` asserted mid-frame: immediate return to IDLE. Results are lost and no `vo` is produced.
- `start` and `set` in the same cycle: `set` wins and the block goes to IDLE.
- `fi` held high while entering ACC via `start`: the frame ends on the next edge, so an empty frame gives sum=0, max=0, count=0.

## Structure
- Shared package / header `nps_acc_pkg` holds:
  - the state encoding (IDLE=0, ACC=1, OUT=2, DONE=3);
  - the localparams SUM_WIDTH = DATA_WIDTH+CNT_WIDTH and MAX_CNT = 2^CNT_WIDTH.
- No sub-module. One FSM process plus one datapath register process.

## Test plan
- Ramp frame: reset, `start`, `datai`=0..511 with `vi`=1 on 512 consecutive cycles, then `fi`=1 → `sumo`=0x1FF00, `maxo`=0x1FF, `cnto`=512, `ovf`=0. `vo` is high for exactly one cycle, and `fo` rises one cycle later and holds.
- Full-scale frame: 512 words of 0xFFFFFF → `sumo`=0x1_FFFF_FE00, `maxo`=0xFFFFFF, `cnto`=512, `ovf`=0.
- Overflow: 513 words of 1 → `sumo`=512, `cnto`=512, `ovf`=1.
- Last word with frame end: words 5, 9, 3, with the final word 3 sent together with `fi` in the same cycle → `sumo`=17, `maxo`=9, `cnto`=3, `vo` in the cycle after.
- Abort:
  - `reset_x` low after 100 words → all outputs 0 and no `vo`;
  - `set` after 100 words → IDLE with no `vo`, then `start` plus 2 words of 7 and `fi` → `sumo`=14.
- Restart from DONE: after the ramp frame, `start` → `fo` drops, outputs clear. A second frame of 4 words of 2 gives `sumo`=8 and `cnto`=4.
